// File: rtl/rand_pack_pkg.sv
// Shared constants and types for the random-symbol byte packer.
package rand_pack_pkg;

  localparam int unsigned SYM_W  = 2;
  localparam int unsigned BYTE_W = 8;
  // Bit-count register is wide enough to hold BYTE_W itself before wrap.
  localparam int unsigned CNT_W  = $clog2(BYTE_W) + 1;

  // Von Neumann symbol codes; 00 and 11 carry no usable bit.
  localparam logic [SYM_W-1:0] VN_ONE  = 2'b10;
  localparam logic [SYM_W-1:0] VN_ZERO = 2'b01;

  localparam logic [BYTE_W-1:0] DROP_MAX = 8'hFF;

  typedef enum logic {
    MODE_RAW = 1'b0,
    MODE_VN  = 1'b1
  } pack_mode_e;

endpackage

// File: rtl/rand_fifo.sv
// Synchronous byte FIFO; push and pop may coincide, including at full.
module rand_fifo
  import rand_pack_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic [BYTE_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [BYTE_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_ok, push_ok;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_count = count_q;
  // Head byte straight from registered storage; zero when nothing is held.
  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

  // Qualify handshakes and compute next pointer/occupancy values.
  always_comb begin
    pop_ok   = i_pop && !o_empty;
    push_ok  = i_push && (!o_full || pop_ok);
    rd_ptr_d = pop_ok  ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    wr_ptr_d = push_ok ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    count_d  = CW'(count_q + CW'(push_ok) - CW'(pop_ok));
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful behind valid pointers.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: rtl/rand_byte_packer.sv
// Packs 2-bit random symbols (raw or von Neumann debiased) into bytes, MSB first,
// buffered in a FIFO with sticky overflow and a saturating drop counter.
module rand_byte_packer
  import rand_pack_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_r_valid,
  input  logic [SYM_W-1:0]       i_r,
  input  logic                   i_debias,
  output logic [BYTE_W-1:0]      o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic [BYTE_W-1:0]      o_drop_cnt
);

  logic [BYTE_W-1:0] sh_q, sh_d;
  logic [CNT_W-2:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  cnt_next;
  pack_mode_e        mode_q, mode_m;
  logic              push_c;
  logic              drop_c;
  logic              overflow_q;
  logic [BYTE_W-1:0] drop_cnt_q;
  logic              fifo_full, fifo_empty;

  // Packer next state: mode is latched at the start of each byte.
  always_comb begin
    mode_m   = (bit_cnt_q == '0) ? pack_mode_e'(i_debias) : mode_q;
    sh_d     = sh_q;
    cnt_next = CNT_W'(bit_cnt_q);
    push_c   = 1'b0;
    if (i_r_valid) begin
      if (mode_m == MODE_RAW) begin
        sh_d     = {sh_q[BYTE_W-SYM_W-1:0], i_r};
        cnt_next = CNT_W'(cnt_next + CNT_W'(SYM_W));
      end else if (i_r == VN_ONE) begin
        sh_d     = {sh_q[BYTE_W-2:0], 1'b1};
        cnt_next = CNT_W'(cnt_next + 1'b1);
      end else if (i_r == VN_ZERO) begin
        sh_d     = {sh_q[BYTE_W-2:0], 1'b0};
        cnt_next = CNT_W'(cnt_next + 1'b1);
      end
    end
    if (cnt_next == CNT_W'(BYTE_W)) begin
      push_c    = 1'b1;
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = cnt_next[CNT_W-2:0];
    end
  end

  // A completed byte is lost only if the FIFO is full and not popping this edge.
  assign drop_c = push_c && fifo_full && !(i_ready && !fifo_empty);

  // Packer and overflow accounting registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      mode_q     <= MODE_RAW;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      mode_q    <= mode_m;
      if (drop_c) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != DROP_MAX) begin
          drop_cnt_q <= BYTE_W'(drop_cnt_q + 1'b1);
        end
      end
    end
  end

  rand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push_c),
    .i_data    (sh_d),
    .i_pop     (i_ready),
    .o_data    (o_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (o_count)
  );

  assign o_valid    = !fifo_empty;
  assign o_overflow = overflow_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rand_byte_packer.sv
// Directed bench for rand_byte_packer: vector table plus hand-written corner sequences.
module tb_rand_byte_packer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       r_valid;
  logic [1:0] r;
  logic       debias;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rand_byte_packer #(.DEPTH(4)) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_r_valid  (r_valid),
    .i_r        (r),
    .i_debias   (debias),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_count    (count),
    .o_overflow (overflow),
    .o_drop_cnt (drop_cnt)
  );

  typedef struct packed {
    logic       rv;
    logic [1:0] r;
    logic       db;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rv_, input logic [1:0] r_, input logic db_,
                              input logic rdy_, input logic ev_, input logic [7:0] ed_,
                              input logic [2:0] ec_);
    vec_t v;
    v.rv = rv_; v.r = r_; v.db = db_; v.rdy = rdy_;
    v.ev = ev_; v.ed = ed_; v.ec = ec_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    r_valid = 1'b0; r = 2'b00; ready = 1'b0;
  endtask

  // Four raw symbols MSB first; ready only on the completing symbol if rdy_last.
  task automatic send_raw_byte(input logic [7:0] b, input logic rdy_last);
    logic [7:0] t;
    t = b;
    debias = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r_valid = 1'b1;
      r       = t[7-2*k -: 2];
      ready   = (k == 3) ? rdy_last : 1'b0;
      step();
    end
    idle();
  endtask

  task automatic drain_check(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, 32'(valid), 32'd1);
    chk({name, "_data"},  32'(data),  32'(exp));
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    debias = 1'b0;
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    step();
    reset_n = 1'b1;

    // Reset state.
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data",  32'(data),  32'h00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);

    // Raw 11,00,10,01 -> C9, popped the next cycle.
    tbl.push_back(mk(1, 2'b11, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b00, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b10, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 0, 1, 1, 8'hC9, 1));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 8'h00, 0));
    // Debias 10,01,00,11,10,10,01,01,10,01 -> B2.
    tbl.push_back(mk(1, 2'b10, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b00, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b11, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b10, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b10, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b10, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 1, 8'hB2, 1));
    tbl.push_back(mk(0, 2'b00, 1, 1, 0, 8'h00, 0));
    // Mid-byte mode change ignored: 11,11 raw then 00,01 with debias=1 -> F1.
    tbl.push_back(mk(1, 2'b11, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b11, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b00, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 1, 8'hF1, 1));
    // Following byte is debiased: 10,01 x4 -> AA after 8 symbols.
    tbl.push_back(mk(1, 2'b10, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b10, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b10, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b10, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 1, 8'hAA, 1));
    tbl.push_back(mk(0, 2'b00, 1, 1, 0, 8'h00, 0));

    foreach (tbl[i]) begin
      r_valid = tbl[i].rv;
      r       = tbl[i].r;
      debias  = tbl[i].db;
      ready   = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_data",  i), 32'(data),  32'(tbl[i].ed));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ec));
    end
    idle();
    debias = 1'b0;

    // Overrun: six bytes into a 4-deep FIFO with no consumer.
    send_raw_byte(8'h11, 1'b0);
    send_raw_byte(8'h22, 1'b0);
    send_raw_byte(8'h33, 1'b0);
    send_raw_byte(8'h44, 1'b0);
    chk("full_ovf_clear", 32'(overflow), 32'd0);
    send_raw_byte(8'h55, 1'b0);
    send_raw_byte(8'h66, 1'b0);
    chk("ovr_count", 32'(count),    32'd4);
    chk("ovr_flag",  32'(overflow), 32'd1);
    chk("ovr_drop",  32'(drop_cnt), 32'd2);
    drain_check("ovr_b0", 8'h11);
    drain_check("ovr_b1", 8'h22);
    drain_check("ovr_b2", 8'h33);
    drain_check("ovr_b3", 8'h44);
    chk("ovr_empty", 32'(count), 32'd0);
    chk("ovr_sticky", 32'(overflow), 32'd1);

    // Reset with a buffered byte and a partial byte, then 01 x4 -> 55.
    send_raw_byte(8'h77, 1'b0);
    for (int k = 0; k < 3; k++) begin
      r_valid = 1'b1; r = 2'b11;
      step();
    end
    do_reset();
    chk("rst2_count", 32'(count),    32'd0);
    chk("rst2_valid", 32'(valid),    32'd0);
    chk("rst2_data",  32'(data),     32'h00);
    chk("rst2_ovf",   32'(overflow), 32'd0);
    chk("rst2_drop",  32'(drop_cnt), 32'd0);
    send_raw_byte(8'h55, 1'b0);
    chk("rst2_byte",  32'(data),  32'h55);
    chk("rst2_cnt1",  32'(count), 32'd1);

    // Full FIFO with a pop on the edge a new byte completes.
    do_reset();
    send_raw_byte(8'hA1, 1'b0);
    send_raw_byte(8'hA2, 1'b0);
    send_raw_byte(8'hA3, 1'b0);
    send_raw_byte(8'hA4, 1'b0);
    chk("pp_full", 32'(count), 32'd4);
    send_raw_byte(8'hA5, 1'b1);
    chk("pp_count", 32'(count),    32'd4);
    chk("pp_ovf",   32'(overflow), 32'd0);
    chk("pp_drop",  32'(drop_cnt), 32'd0);
    drain_check("pp_b0", 8'hA2);
    drain_check("pp_b1", 8'hA3);
    drain_check("pp_b2", 8'hA4);
    drain_check("pp_b3", 8'hA5);
    chk("pp_empty", 32'(count), 32'd0);
    chk("pp_data0", 32'(data),  32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
